// File: rtl/time_pkg.sv
// Shared types and BCD helpers for the stopwatch/timer.
// Times are mm:ss held as four BCD digits.
package time_pkg;

   localparam int unsigned LAP_DEPTH_DEFAULT = 4;

   typedef struct packed {
      logic [3:0] m_tens;
      logic [3:0] m_ones;
      logic [3:0] s_tens;
      logic [3:0] s_ones;
   } bcd_time_t;

   localparam bcd_time_t BCD_ZERO = '{m_tens: 4'd0, m_ones: 4'd0, s_tens: 4'd0, s_ones: 4'd0};
   localparam bcd_time_t BCD_ONE  = '{m_tens: 4'd0, m_ones: 4'd0, s_tens: 4'd0, s_ones: 4'd1};
   localparam bcd_time_t BCD_MAX  = '{m_tens: 4'd5, m_ones: 4'd9, s_tens: 4'd5, s_ones: 4'd9};

   // One second forward; 59:59 wraps to 00:00.
   function automatic bcd_time_t bcd_inc(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.s_ones != 4'd9) begin
         r.s_ones = t.s_ones + 4'd1;
      end else begin
         r.s_ones = 4'd0;
         if (t.s_tens != 4'd5) begin
            r.s_tens = t.s_tens + 4'd1;
         end else begin
            r.s_tens = 4'd0;
            if (t.m_ones != 4'd9) begin
               r.m_ones = t.m_ones + 4'd1;
            end else begin
               r.m_ones = 4'd0;
               r.m_tens = (t.m_tens != 4'd5) ? t.m_tens + 4'd1 : 4'd0;
            end
         end
      end
      return r;
   endfunction

   // One second back; callers never pass 00:00.
   function automatic bcd_time_t bcd_dec(input bcd_time_t t);
      bcd_time_t r;
      r = t;
      if (t.s_ones != 4'd0) begin
         r.s_ones = t.s_ones - 4'd1;
      end else begin
         r.s_ones = 4'd9;
         if (t.s_tens != 4'd0) begin
            r.s_tens = t.s_tens - 4'd1;
         end else begin
            r.s_tens = 4'd5;
            if (t.m_ones != 4'd0) begin
               r.m_ones = t.m_ones - 4'd1;
            end else begin
               r.m_ones = 4'd9;
               r.m_tens = t.m_tens - 4'd1;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a single-cycle tick every TICK_DIV cycles while running.
module tick_prescaler #(
   parameter int unsigned TICK_DIV = 10_000_000
) (
   input  logic clk,
   input  logic nrst,
   input  logic i_run,
   input  logic i_clear,
   output logic o_tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_count;

   assign o_tick = i_run & ~i_clear & (r_count == LAST);

   // Stopping discards any partial tick so the next run starts a full period.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_count <= '0;
      end else if (i_clear || !i_run || o_tick) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + 1'b1;
      end
   end

endmodule

// File: rtl/time_keeper.sv
// Stopwatch / countdown timer with BCD mm:ss time and a circular lap buffer.
// Priority each cycle: clear > enable > enable_decrement > enable_increment.
module time_keeper
   import time_pkg::*;
#(
   parameter int unsigned TICK_DIV  = 10_000_000,
   parameter int unsigned LAP_DEPTH = LAP_DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        i_clear,
   input  logic        i_enable,
   input  logic        i_enable_increment,
   input  logic        i_enable_decrement,
   input  logic        i_inc_pulse,
   input  logic        i_write,
   input  logic        i_read,
   output logic [15:0] o_cur_time,
   output logic [15:0] o_lap_time,
   output logic        o_flag
);

   localparam int unsigned PW = (LAP_DEPTH > 1) ? $clog2(LAP_DEPTH) : 1;

   bcd_time_t         r_time;
   bcd_time_t         w_time_d;
   logic              r_flag;
   logic              w_flag_d;
   logic              w_run;
   logic              w_tick;
   bcd_time_t         r_mem [LAP_DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;

   assign w_run = i_enable | i_enable_decrement;

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk     (clk),
      .nrst    (nrst),
      .i_run   (w_run),
      .i_clear (i_clear),
      .o_tick  (w_tick)
   );

   always_comb begin
      w_time_d = r_time;
      w_flag_d = r_flag;
      if (i_clear) begin
         w_time_d = BCD_ZERO;
         w_flag_d = 1'b0;
      end else if (i_enable) begin
         if (w_tick && (r_time != BCD_MAX)) begin
            w_time_d = bcd_inc(r_time);
         end
      end else if (i_enable_decrement) begin
         // Flag fires on reaching zero, or immediately if started at zero.
         if (r_time == BCD_ZERO) begin
            w_flag_d = 1'b1;
         end else if (w_tick) begin
            w_time_d = bcd_dec(r_time);
            if (r_time == BCD_ONE) begin
               w_flag_d = 1'b1;
            end
         end
      end else if (i_enable_increment && i_inc_pulse) begin
         w_time_d = bcd_inc(r_time);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_time <= BCD_ZERO;
         r_flag <= 1'b0;
      end else begin
         r_time <= w_time_d;
         r_flag <= w_flag_d;
      end
   end

   // Lap buffer ignores clear; the newest entry becomes the read point on write.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int i = 0; i < LAP_DEPTH; i++) begin
            r_mem[i] <= BCD_ZERO;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else if (i_write) begin
         r_mem[r_wr_ptr] <= r_time;
         r_rd_ptr        <= r_wr_ptr;
         r_wr_ptr        <= r_wr_ptr + 1'b1;
      end else if (i_read) begin
         r_rd_ptr <= r_rd_ptr - 1'b1;
      end
   end

   assign o_cur_time = r_time;
   assign o_lap_time = r_mem[r_rd_ptr];
   assign o_flag     = r_flag;

endmodule

// File: tb/tb_time_keeper.sv
// Randomised and directed checks of time_keeper against a seconds-based model.
module tb_time_keeper;

   localparam int unsigned TDIV  = 4;
   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        clear = 1'b0, enable = 1'b0, en_inc = 1'b0, en_dec = 1'b0;
   logic        inc_pulse = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [15:0] cur_time, lap_time;
   logic        flag;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: time as plain seconds, laps as seconds.
   int m_secs, m_pre, m_wr, m_rd;
   bit m_flag;
   int m_mem [DEPTH];

   time_keeper #(
      .TICK_DIV  (TDIV),
      .LAP_DEPTH (DEPTH)
   ) dut (
      .clk                (clk),
      .nrst               (nrst),
      .i_clear            (clear),
      .i_enable           (enable),
      .i_enable_increment (en_inc),
      .i_enable_decrement (en_dec),
      .i_inc_pulse        (inc_pulse),
      .i_write            (wr),
      .i_read             (rd),
      .o_cur_time         (cur_time),
      .o_lap_time         (lap_time),
      .o_flag             (flag)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int s);
      int m, sec;
      m   = s / 60;
      sec = s % 60;
      return {4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
   endfunction

   task automatic model_reset();
      m_secs = 0; m_pre = 0; m_wr = 0; m_rd = 0; m_flag = 1'b0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
   endtask

   task automatic model_step();
      int  old;
      bit  run, tick;
      old  = m_secs;
      run  = !clear && (enable || en_dec);
      tick = run && (m_pre == TDIV - 1);
      if (clear) begin
         m_secs = 0; m_pre = 0; m_flag = 1'b0;
      end else begin
         m_pre = (run && !tick) ? m_pre + 1 : 0;
         if (enable) begin
            if (tick && m_secs < 3599) m_secs++;
         end else if (en_dec) begin
            if (m_secs == 0) m_flag = 1'b1;
            else if (tick) begin
               if (m_secs == 1) m_flag = 1'b1;
               m_secs--;
            end
         end else if (en_inc && inc_pulse) begin
            m_secs = (m_secs + 1) % 3600;
         end
      end
      if (wr) begin
         m_mem[m_wr] = old;
         m_rd = m_wr;
         m_wr = (m_wr + 1) % DEPTH;
      end else if (rd) begin
         m_rd = (m_rd + DEPTH - 1) % DEPTH;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      clear = 0; enable = 0; en_inc = 0; en_dec = 0; inc_pulse = 0; wr = 0; rd = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      nrst = 1'b0;
      model_reset();
      #12 nrst = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (cur_time !== 16'h0000) begin
         n_fail++; $display("FAIL reset_cur: got %h want 0000", cur_time);
      end
      n_checks++;
      if (lap_time !== 16'h0000) begin
         n_fail++; $display("FAIL reset_lap: got %h want 0000", lap_time);
      end
      n_checks++;
      if (flag !== 1'b0) begin
         n_fail++; $display("FAIL reset_flag: got %b want 0", flag);
      end
      // An unwritten entry reached by stepping back also reads zero
      rd = 1; cycle(); rd = 0;
      n_checks++;
      if (lap_time !== 16'h0000) begin
         n_fail++; $display("FAIL unwritten_lap: got %h want 0000", lap_time);
      end
   endtask

   task automatic test_count_up();
      idle_inputs();
      clear = 1; cycle(); clear = 0;
      enable = 1;
      for (int k = 1; k <= 240; k++) begin
         cycle();
         n_checks++;
         if (cur_time !== to_bcd(m_secs) || cur_time[7:4] > 4'd5 || cur_time[3:0] > 4'd9) begin
            n_fail++;
            $display("FAIL count_up c%0d: got %h want %h", k, cur_time, to_bcd(m_secs));
         end
         if (k == 236) begin
            n_checks++;
            if (cur_time !== 16'h0059) begin
               n_fail++; $display("FAIL count_059: got %h want 0059", cur_time);
            end
         end
      end
      n_checks++;
      if (cur_time !== 16'h0100) begin
         n_fail++; $display("FAIL count_100: got %h want 0100", cur_time);
      end
      enable = 0;
   endtask

   task automatic test_countdown();
      idle_inputs();
      clear = 1; cycle(); clear = 0;
      en_inc = 1; inc_pulse = 1; cycle(); cycle(); en_inc = 0; inc_pulse = 0;
      n_checks++;
      if (cur_time !== 16'h0002) begin
         n_fail++; $display("FAIL set_0002: got %h want 0002", cur_time);
      end
      en_dec = 1;
      for (int k = 1; k <= 12; k++) begin
         cycle();
         n_checks++;
         if (cur_time !== to_bcd(m_secs) || flag !== m_flag) begin
            n_fail++;
            $display("FAIL countdown c%0d: got %h/%b want %h/%b", k, cur_time, flag,
                     to_bcd(m_secs), m_flag);
         end
         if (k == 4) begin
            n_checks++;
            if (cur_time !== 16'h0001 || flag !== 1'b0) begin
               n_fail++; $display("FAIL dec_0001: got %h/%b want 0001/0", cur_time, flag);
            end
         end
         if (k == 7) begin
            n_checks++;
            if (flag !== 1'b0) begin
               n_fail++; $display("FAIL flag_early: got %b want 0", flag);
            end
         end
         if (k == 8) begin
            n_checks++;
            if (cur_time !== 16'h0000 || flag !== 1'b1) begin
               n_fail++; $display("FAIL dec_0000: got %h/%b want 0000/1", cur_time, flag);
            end
         end
      end
      en_dec = 0; cycle(); cycle();
      n_checks++;
      if (flag !== 1'b1) begin
         n_fail++; $display("FAIL flag_sticky: got %b want 1", flag);
      end
      clear = 1; cycle(); clear = 0;
      n_checks++;
      if (flag !== 1'b0) begin
         n_fail++; $display("FAIL flag_clear: got %b want 0", flag);
      end
   endtask

   task automatic test_dec_zero();
      idle_inputs();
      clear = 1; cycle(); clear = 0;
      en_dec = 1; cycle(); en_dec = 0;
      n_checks++;
      if (flag !== 1'b1 || cur_time !== 16'h0000) begin
         n_fail++; $display("FAIL dec_zero: got %h/%b want 0000/1", cur_time, flag);
      end
      clear = 1; cycle(); clear = 0;
   endtask

   task automatic test_laps();
      int exp_r [4];
      exp_r = '{4, 3, 2, 5};
      idle_inputs();
      clear = 1; cycle(); clear = 0;
      for (int v = 1; v <= 5; v++) begin
         en_inc = 1; inc_pulse = 1; cycle(); en_inc = 0; inc_pulse = 0;
         wr = 1; cycle(); wr = 0;
         n_checks++;
         if (lap_time !== to_bcd(v) || lap_time !== to_bcd(m_mem[m_rd])) begin
            n_fail++; $display("FAIL lap_write%0d: got %h want %h", v, lap_time, to_bcd(v));
         end
      end
      for (int i = 0; i < 4; i++) begin
         rd = 1; cycle(); rd = 0;
         n_checks++;
         if (lap_time !== to_bcd(exp_r[i])) begin
            n_fail++;
            $display("FAIL lap_read%0d: got %h want %h", i, lap_time, to_bcd(exp_r[i]));
         end
      end
   endtask

   task automatic test_saturate();
      idle_inputs();
      clear = 1; cycle(); clear = 0;
      en_inc = 1; inc_pulse = 1;
      for (int k = 0; k < 3599; k++) cycle();
      en_inc = 0; inc_pulse = 0;
      n_checks++;
      if (cur_time !== 16'h5959) begin
         n_fail++; $display("FAIL reach_5959: got %h want 5959", cur_time);
      end
      enable = 1;
      for (int k = 0; k < 8; k++) cycle();
      enable = 0;
      n_checks++;
      if (cur_time !== 16'h5959) begin
         n_fail++; $display("FAIL hold_5959: got %h want 5959", cur_time);
      end
      en_inc = 1; inc_pulse = 1; cycle(); en_inc = 0; inc_pulse = 0;
      n_checks++;
      if (cur_time !== 16'h0000) begin
         n_fail++; $display("FAIL wrap_0000: got %h want 0000", cur_time);
      end
   endtask

   task automatic test_reset_mid();
      idle_inputs();
      clear = 1; cycle(); clear = 0;
      enable = 1;
      for (int k = 0; k < 9; k++) cycle();
      wr = 1; cycle(); wr = 0;
      n_checks++;
      if (cur_time !== 16'h0002 || lap_time !== 16'h0002) begin
         n_fail++; $display("FAIL pre_reset: got %h/%h want 0002/0002", cur_time, lap_time);
      end
      nrst = 1'b0;
      #2;
      model_reset();
      n_checks++;
      if (cur_time !== 16'h0000 || lap_time !== 16'h0000 || flag !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: got %h/%h/%b want 0000/0000/0", cur_time, lap_time, flag);
      end
      @(negedge clk);
      nrst = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         cycle();
         n_checks++;
         if (cur_time !== ((k == 4) ? 16'h0001 : 16'h0000)) begin
            n_fail++; $display("FAIL post_reset_tick c%0d: got %h", k, cur_time);
         end
      end
      enable = 0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 1500; k++) begin
         clear     = ($urandom_range(0, 63) == 0);
         enable    = ($urandom_range(0, 3) == 0);
         en_dec    = ($urandom_range(0, 4) == 0);
         en_inc    = ($urandom_range(0, 1) == 0);
         inc_pulse = ($urandom_range(0, 2) == 0);
         wr        = ($urandom_range(0, 7) == 0);
         rd        = ($urandom_range(0, 5) == 0);
         cycle();
         n_checks++;
         if (cur_time !== to_bcd(m_secs) || lap_time !== to_bcd(m_mem[m_rd]) ||
             flag !== m_flag) begin
            n_fail++;
            $display("FAIL random c%0d: got %h/%h/%b want %h/%h/%b", k, cur_time, lap_time,
                     flag, to_bcd(m_secs), to_bcd(m_mem[m_rd]), m_flag);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_countdown();
      test_dec_zero();
      test_laps();
      test_saturate();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
